// File: rtl/dsi_packet_arbiter_pkg.sv
// Shared types and constants for the DSI packet arbiter: arbiter state
// encoding, DCS data types and the payload beat geometry.
package dsi_packet_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_TG       = 3'd1,
        ARB_CMD_HDR  = 3'd2,
        ARB_CMD_PAY  = 3'd3,
        ARB_CMD_DONE = 3'd4
    } arb_state_t;

    localparam logic [5:0] PTYPE_DCS_SHORT_WRITE = 6'h05;
    localparam logic [5:0] PTYPE_DCS_LONG_WRITE  = 6'h39;

    // Payload bytes carried by one beat: three bytes (RGB888) per pixel lane.
    function automatic logic [15:0] bytes_per_beat(input int unsigned ppc);
        return 16'(3 * ppc);
    endfunction

endpackage

// File: rtl/dsi_packet_arbiter.sv
// Shares the DSI packet assembler between the video timing generator (always
// preferred) and the host command path, locking each packet until consumed.
module dsi_packet_arbiter
    import dsi_packet_arbiter_pkg::*;
#(
    parameter int unsigned g_pixels_per_clock = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              tg_req_i,
    input  logic                              tg_islong_i,
    input  logic [5:0]                        tg_type_i,
    input  logic [15:0]                       tg_wcount_i,
    input  logic [15:0]                       tg_command_i,
    input  logic [24*g_pixels_per_clock-1:0]  tg_payload_i,
    input  logic                              tg_last_i,
    output logic                              tg_dreq_o,
    output logic                              tg_stall_o,
    input  logic                              cmd_req_i,
    input  logic                              cmd_islong_i,
    input  logic [5:0]                        cmd_type_i,
    input  logic [15:0]                       cmd_wcount_i,
    input  logic [15:0]                       cmd_command_i,
    input  logic [24*g_pixels_per_clock-1:0]  cmd_payload_i,
    input  logic                              cmd_last_i,
    output logic                              cmd_dreq_o,
    output logic                              cmd_done_o,
    output logic [15:0]                       cmd_count_o,
    output logic                              p_req_o,
    output logic                              p_islong_o,
    output logic [5:0]                        p_type_o,
    output logic [15:0]                       p_wcount_o,
    output logic [15:0]                       p_command_o,
    output logic [24*g_pixels_per_clock-1:0]  p_payload_o,
    output logic                              p_last_o,
    input  logic                              p_dreq_i
);

    localparam logic [15:0] BPB = bytes_per_beat(g_pixels_per_clock);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic [15:0] r_remaining;
    logic [15:0] r_cmd_count;

    logic w_sel_tg;
    logic w_sel_cmd;
    logic w_in_done;
    logic w_hdr_has_payload;
    logic w_pay_last;

    assign w_sel_tg          = (r_state == ARB_TG);
    assign w_sel_cmd         = (r_state == ARB_CMD_HDR) || (r_state == ARB_CMD_PAY);
    assign w_in_done         = (r_state == ARB_CMD_DONE);
    assign w_hdr_has_payload = cmd_islong_i && (cmd_wcount_i != 16'd0);
    assign w_pay_last        = (r_remaining <= BPB);

    // NOTE: every output of a combinational block gets a default before the
    // case, otherwise an unassigned path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (tg_req_i)
                    w_next_state = ARB_TG;
                else if (cmd_req_i)
                    w_next_state = ARB_CMD_HDR;
            end
            ARB_TG: begin
                if (!tg_req_i)
                    w_next_state = ARB_IDLE;
            end
            ARB_CMD_HDR: begin
                // An accepted header commits the packet even if the source drops req.
                if (p_dreq_i)
                    w_next_state = w_hdr_has_payload ? ARB_CMD_PAY : ARB_CMD_DONE;
                else if (!cmd_req_i)
                    w_next_state = ARB_IDLE;
            end
            ARB_CMD_PAY: begin
                if (p_dreq_i && w_pay_last)
                    w_next_state = ARB_CMD_DONE;
            end
            ARB_CMD_DONE: w_next_state = ARB_IDLE;
            default:      w_next_state = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            r_state <= ARB_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_remaining <= 16'd0;
            r_cmd_count <= 16'd0;
        end else begin
            if ((r_state == ARB_CMD_HDR) && p_dreq_i && w_hdr_has_payload)
                r_remaining <= cmd_wcount_i;
            else if ((r_state == ARB_CMD_PAY) && p_dreq_i)
                r_remaining <= w_pay_last ? 16'd0 : (r_remaining - BPB);
            if (w_in_done)
                r_cmd_count <= r_cmd_count + 16'd1;
        end
    end

    // Zero-latency mux on registered state keeps TG's same-cycle handshake.
    always_comb begin
        p_req_o     = 1'b0;
        p_islong_o  = 1'b0;
        p_type_o    = '0;
        p_wcount_o  = '0;
        p_command_o = '0;
        p_payload_o = '0;
        p_last_o    = 1'b0;
        if (w_sel_tg) begin
            p_req_o     = tg_req_i;
            p_islong_o  = tg_islong_i;
            p_type_o    = tg_type_i;
            p_wcount_o  = tg_wcount_i;
            p_command_o = tg_command_i;
            p_payload_o = tg_payload_i;
            p_last_o    = tg_last_i;
        end else if (w_sel_cmd) begin
            p_req_o     = 1'b1;
            p_islong_o  = cmd_islong_i;
            p_type_o    = cmd_type_i;
            p_wcount_o  = cmd_wcount_i;
            p_command_o = cmd_command_i;
            p_payload_o = cmd_payload_i;
            p_last_o    = cmd_last_i;
        end
    end

    assign tg_dreq_o   = p_dreq_i & w_sel_tg;
    assign cmd_dreq_o  = p_dreq_i & w_sel_cmd;
    assign cmd_done_o  = w_in_done;
    assign tg_stall_o  = tg_req_i & (w_sel_cmd | w_in_done);
    assign cmd_count_o = r_cmd_count;

endmodule

// File: tb/tb_dsi_packet_arbiter.sv
// Self-checking bench for dsi_packet_arbiter: a cycle table for the basic
// handshakes, hand sequences for stall/reset corners, then random traffic.
module tb_dsi_packet_arbiter;
    import dsi_packet_arbiter_pkg::*;

    localparam int PPC = 1;
    localparam int PW  = 24 * PPC;
    localparam int BPB = 3 * PPC;
    localparam logic [5:0] TG_TYPE = 6'h19;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          tg_req_i, tg_islong_i, tg_last_i;
    logic [5:0]    tg_type_i;
    logic [15:0]   tg_wcount_i, tg_command_i;
    logic [PW-1:0] tg_payload_i;
    logic          tg_dreq_o, tg_stall_o;
    logic          cmd_req_i, cmd_islong_i, cmd_last_i;
    logic [5:0]    cmd_type_i;
    logic [15:0]   cmd_wcount_i, cmd_command_i;
    logic [PW-1:0] cmd_payload_i;
    logic          cmd_dreq_o, cmd_done_o;
    logic [15:0]   cmd_count_o;
    logic          p_req_o, p_islong_o, p_last_o;
    logic [5:0]    p_type_o;
    logic [15:0]   p_wcount_o, p_command_o;
    logic [PW-1:0] p_payload_o;
    logic          p_dreq_i;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_count;

    dsi_packet_arbiter #(.g_pixels_per_clock(PPC)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .tg_req_i(tg_req_i), .tg_islong_i(tg_islong_i), .tg_type_i(tg_type_i),
        .tg_wcount_i(tg_wcount_i), .tg_command_i(tg_command_i),
        .tg_payload_i(tg_payload_i), .tg_last_i(tg_last_i),
        .tg_dreq_o(tg_dreq_o), .tg_stall_o(tg_stall_o),
        .cmd_req_i(cmd_req_i), .cmd_islong_i(cmd_islong_i), .cmd_type_i(cmd_type_i),
        .cmd_wcount_i(cmd_wcount_i), .cmd_command_i(cmd_command_i),
        .cmd_payload_i(cmd_payload_i), .cmd_last_i(cmd_last_i),
        .cmd_dreq_o(cmd_dreq_o), .cmd_done_o(cmd_done_o), .cmd_count_o(cmd_count_o),
        .p_req_o(p_req_o), .p_islong_o(p_islong_o), .p_type_o(p_type_o),
        .p_wcount_o(p_wcount_o), .p_command_o(p_command_o),
        .p_payload_o(p_payload_o), .p_last_o(p_last_o), .p_dreq_i(p_dreq_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int tg, cmd, lng, wc, ctype, dreq;
        int preq, ptype, tgd, cmdd, done, stall, cnt;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: one header beat, plus ceil(wcount/BPB) payload beats for a non-empty long packet.
    function automatic int expected_beats(input logic islong, input logic [15:0] wc);
        if (islong && wc != 16'd0)
            return 1 + (int'(wc) + BPB - 1) / BPB;
        return 1;
    endfunction

    // Issues one CMD packet starting from an IDLE cycle; optionally raises TG once the header is taken.
    task automatic run_cmd(input logic islong, input logic [15:0] wc, input int dreq_pct, input logic raise_tg);
        int   pulses = 0;
        logic done = 1'b0;
        logic took;
        cmd_req_i     = 1'b1;
        cmd_islong_i  = islong;
        cmd_wcount_i  = wc;
        cmd_type_i    = islong ? PTYPE_DCS_LONG_WRITE : PTYPE_DCS_SHORT_WRITE;
        cmd_command_i = 16'($urandom);
        cmd_payload_i = PW'($urandom);
        cmd_last_i    = 1'($urandom);
        for (int g = 0; g < 400 && !done; g++) begin
            p_dreq_i = (int'($urandom_range(0, 99)) < dreq_pct);
            #1;
            took = cmd_dreq_o;
            check("tg_dreq_during_cmd", 32'(tg_dreq_o), 32'(0));
            if (tg_req_i)
                check("tg_stall_during_cmd", 32'(tg_stall_o), 32'(1));
            if (took) begin
                if (pulses == 0) begin
                    check("cmd_hdr_command", 32'(p_command_o), 32'(cmd_command_i));
                    check("cmd_hdr_wcount", 32'(p_wcount_o), 32'(cmd_wcount_i));
                    check("cmd_hdr_islong", 32'(p_islong_o), 32'(cmd_islong_i));
                    check("cmd_hdr_last", 32'(p_last_o), 32'(cmd_last_i));
                end
                pulses++;
                check("cmd_payload_route", 32'(p_payload_o), 32'(cmd_payload_i));
                check("cmd_type_route", 32'(p_type_o), 32'(cmd_type_i));
                check("cmd_preq_high", 32'(p_req_o), 32'(1));
            end
            if (cmd_done_o) begin
                done = 1'b1;
                cmd_req_i = 1'b0;
                check("done_preq_low", 32'(p_req_o), 32'(0));
            end
            tick();
            if (took)
                cmd_payload_i = PW'($urandom);
            if (raise_tg && pulses >= 1 && !done)
                tg_req_i = 1'b1;
        end
        cmd_req_i = 1'b0;
        check("cmd_done_seen", 32'(done), 32'(1));
        check("cmd_beats", 32'(pulses), 32'(expected_beats(islong, wc)));
        if (done)
            exp_count = exp_count + 16'd1;
        #1;
        check("cmd_count", 32'(cmd_count_o), 32'(exp_count));
        check("done_single_cycle", 32'(cmd_done_o), 32'(0));
    endtask

    // TG burst from IDLE: first cycle is the grant decision, then pass-through.
    task automatic tg_burst(input int len);
        for (int i = 0; i < len; i++) begin
            tg_req_i     = 1'b1;
            p_dreq_i     = 1'($urandom_range(0, 1));
            tg_payload_i = PW'($urandom);
            tg_type_i    = 6'($urandom);
            #1;
            if (i == 0) begin
                check("tg_idle_preq", 32'(p_req_o), 32'(0));
                check("tg_idle_dreq", 32'(tg_dreq_o), 32'(0));
            end else begin
                check("tg_dreq", 32'(tg_dreq_o), 32'(p_dreq_i));
                check("tg_payload", 32'(p_payload_o), 32'(tg_payload_i));
                check("tg_type", 32'(p_type_o), 32'(tg_type_i));
                check("tg_preq", 32'(p_req_o), 32'(1));
                check("tg_no_stall", 32'(tg_stall_o), 32'(0));
            end
            check("tg_cmd_dreq", 32'(cmd_dreq_o), 32'(0));
            tick();
        end
        tg_req_i = 1'b0;
        p_dreq_i = 1'b0;
        #1;
        check("tg_release_preq", 32'(p_req_o), 32'(0));
        tick();
    endtask

    initial begin
        //          tg cmd lng wc ctype dreq | preq ptype tgd cmdd done stall cnt
        vecs[0]  = '{0, 1, 0, 0, 'h05, 0,   0, 'h00, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 'h05, 0,   1, 'h05, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 'h05, 0,   1, 'h05, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 'h05, 1,   1, 'h05, 0, 1, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 'h05, 0,   0, 'h00, 0, 0, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 'h05, 0,   0, 'h00, 0, 0, 0, 0, 1};
        vecs[6]  = '{1, 1, 0, 0, 'h05, 0,   0, 'h00, 0, 0, 0, 0, 1};
        vecs[7]  = '{1, 1, 0, 0, 'h05, 1,   1, 'h19, 1, 0, 0, 0, 1};
        vecs[8]  = '{0, 1, 0, 0, 'h05, 0,   0, 'h19, 0, 0, 0, 0, 1};
        vecs[9]  = '{0, 1, 0, 0, 'h05, 0,   0, 'h00, 0, 0, 0, 0, 1};
        vecs[10] = '{0, 1, 0, 0, 'h05, 1,   1, 'h05, 0, 1, 0, 0, 1};
        vecs[11] = '{0, 0, 0, 0, 'h05, 0,   0, 'h00, 0, 0, 1, 0, 1};
        vecs[12] = '{0, 1, 1, 0, 'h39, 0,   0, 'h00, 0, 0, 0, 0, 2};
        vecs[13] = '{0, 1, 1, 0, 'h39, 1,   1, 'h39, 0, 1, 0, 0, 2};
        vecs[14] = '{0, 0, 0, 0, 'h05, 0,   0, 'h00, 0, 0, 1, 0, 2};
        vecs[15] = '{0, 1, 0, 0, 'h05, 0,   0, 'h00, 0, 0, 0, 0, 3};
        vecs[16] = '{0, 0, 0, 0, 'h05, 0,   1, 'h05, 0, 0, 0, 0, 3};
        vecs[17] = '{0, 0, 0, 0, 'h05, 0,   0, 'h00, 0, 0, 0, 0, 3};
        vecs[18] = '{0, 0, 0, 0, 'h05, 0,   0, 'h00, 0, 0, 0, 0, 3};

        rst_n_i = 1'b0;
        tg_req_i = 1'b0; tg_islong_i = 1'b0; tg_last_i = 1'b0; tg_type_i = TG_TYPE;
        tg_wcount_i = 16'h0000; tg_command_i = 16'h0000; tg_payload_i = '0;
        cmd_req_i = 1'b0; cmd_islong_i = 1'b0; cmd_last_i = 1'b0;
        cmd_type_i = PTYPE_DCS_SHORT_WRITE; cmd_wcount_i = 16'h0000;
        cmd_command_i = 16'h0011; cmd_payload_i = '0;
        p_dreq_i = 1'b1;
        exp_count = 16'd0;
        tick();
        tick();
        #1;
        check("reset_preq", 32'(p_req_o), 32'(0));
        check("reset_cmd_dreq", 32'(cmd_dreq_o), 32'(0));
        check("reset_tg_dreq", 32'(tg_dreq_o), 32'(0));
        check("reset_done", 32'(cmd_done_o), 32'(0));
        check("reset_count", 32'(cmd_count_o), 32'(0));
        check("reset_payload", 32'(p_payload_o), 32'(0));
        p_dreq_i = 1'b0;
        rst_n_i  = 1'b1;

        for (int i = 0; i < NV; i++) begin
            tg_req_i     = 1'(vecs[i].tg);
            cmd_req_i    = 1'(vecs[i].cmd);
            cmd_islong_i = 1'(vecs[i].lng);
            cmd_wcount_i = 16'(vecs[i].wc);
            cmd_type_i   = 6'(vecs[i].ctype);
            p_dreq_i     = 1'(vecs[i].dreq);
            #1;
            check($sformatf("vec%0d_preq", i), 32'(p_req_o), 32'(vecs[i].preq));
            check($sformatf("vec%0d_ptype", i), 32'(p_type_o), 32'(vecs[i].ptype));
            check($sformatf("vec%0d_tg_dreq", i), 32'(tg_dreq_o), 32'(vecs[i].tgd));
            check($sformatf("vec%0d_cmd_dreq", i), 32'(cmd_dreq_o), 32'(vecs[i].cmdd));
            check($sformatf("vec%0d_done", i), 32'(cmd_done_o), 32'(vecs[i].done));
            check($sformatf("vec%0d_stall", i), 32'(tg_stall_o), 32'(vecs[i].stall));
            check($sformatf("vec%0d_count", i), 32'(cmd_count_o), 32'(vecs[i].cnt));
            tick();
        end
        cmd_req_i = 1'b0;
        tg_req_i  = 1'b0;
        p_dreq_i  = 1'b0;
        exp_count = 16'd3;

        // Long packet, 7 bytes at 3 bytes/beat: header plus 3 payload beats.
        run_cmd(1'b1, 16'd7, 100, 1'b0);

        // TG arrives mid-payload: stalled until done, granted after the following IDLE.
        run_cmd(1'b1, 16'd9, 100, 1'b1);
        p_dreq_i = 1'b1;
        #1;
        check("post_done_idle_stall", 32'(tg_stall_o), 32'(0));
        check("post_done_idle_tg_dreq", 32'(tg_dreq_o), 32'(0));
        tick();
        check("tg_grant_preq", 32'(p_req_o), 32'(1));
        check("tg_grant_dreq", 32'(tg_dreq_o), 32'(1));
        check("tg_grant_stall", 32'(tg_stall_o), 32'(0));
        tg_req_i = 1'b0;
        p_dreq_i = 1'b0;
        tick();

        // Reset while streaming payload aborts silently and clears the counter.
        cmd_req_i = 1'b1; cmd_islong_i = 1'b1; cmd_wcount_i = 16'd12;
        cmd_type_i = PTYPE_DCS_LONG_WRITE; p_dreq_i = 1'b1;
        tick(); tick(); tick();
        check("rst_pre_payload_beat", 32'(cmd_dreq_o), 32'(1));
        rst_n_i   = 1'b0;
        cmd_req_i = 1'b0;
        tick();
        check("rst_mid_preq", 32'(p_req_o), 32'(0));
        check("rst_mid_cmd_dreq", 32'(cmd_dreq_o), 32'(0));
        check("rst_mid_done", 32'(cmd_done_o), 32'(0));
        check("rst_mid_count", 32'(cmd_count_o), 32'(0));
        check("rst_mid_payload", 32'(p_payload_o), 32'(0));
        rst_n_i   = 1'b1;
        p_dreq_i  = 1'b0;
        exp_count = 16'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_after_done", 32'(cmd_done_o), 32'(0));
            check("rst_after_count", 32'(cmd_count_o), 32'(0));
        end

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 2) == 0)
                tg_burst(int'($urandom_range(1, 8)));
            else
                run_cmd(1'($urandom_range(0, 1)), 16'($urandom_range(0, 40)),
                        int'($urandom_range(30, 100)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
